// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one SRAM port between NUM_REQ requesters, with
// bounded locked bursts and a tag pipeline that routes read data back to its issuer.
module sram_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int SRAM_LAT  = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        sram_write_enable,
    output logic [ADDR_W-1:0]           sram_write_address,
    output logic [DATA_W-1:0]           sram_write_data,
    output logic [ADDR_W-1:0]           sram_read_address,
    input  logic [DATA_W-1:0]           sram_read_data,
    output logic                        busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [NUM_REQ-1:0] tag_issue_q, tag_issue_d;
    logic [NUM_REQ-1:0] tag_pipe_q [SRAM_LAT];
    logic [NUM_REQ-1:0] tag_pipe_d [SRAM_LAT];

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
    logic               grant_any;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   grant_idx_inc;
    logic [IDX_W:0]     cand_sum;
    logic               inflight;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
            // Gated by reset_n so no requester sees a grant while reset is applied.
            assign req_ready[gi] = reset_n && grant_any && (grant_idx == IDX_W'(gi));
        end
    endgenerate

    // Descending scan so the last hit is the first valid requester at or after ptr_q.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        if (state_q == ST_LOCKED) begin
            grant_any = req_valid[owner_q];
            grant_idx = owner_q;
        end else begin
            for (int off = NUM_REQ - 1; off >= 0; off--) begin
                cand_sum = {1'b0, ptr_q} + (IDX_W + 1)'(off);
                if (cand_sum >= NUM_REQ_W) begin
                    cand_sum = cand_sum - NUM_REQ_W;
                end
                if (req_valid[cand_sum[IDX_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = cand_sum[IDX_W-1:0];
                end
            end
        end
    end

    assign grant_idx_inc = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        raddr_d     = raddr_q;
        tag_issue_d = req_ready & ~req_we;
        if (grant_any) begin
            if (req_we[grant_idx]) begin
                we_d    = 1'b1;
                waddr_d = addr_arr[grant_idx];
                wdata_d = wdata_arr[grant_idx];
            end else begin
                raddr_d = addr_arr[grant_idx];
            end
            case (state_q)
                ST_OPEN: begin
                    if (req_lock[grant_idx]) begin
                        state_d     = ST_LOCKED;
                        owner_d     = grant_idx;
                        burst_cnt_d = CNT_W'(1);
                    end else begin
                        ptr_d = grant_idx_inc;
                    end
                end
                default: begin
                    // The beat that would reach MAX_BURST releases regardless of req_lock.
                    if (!req_lock[grant_idx] || (burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        state_d     = ST_OPEN;
                        burst_cnt_d = '0;
                        ptr_d       = grant_idx_inc;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        tag_pipe_d[0] = tag_issue_q;
        for (int j = 1; j < SRAM_LAT; j++) begin
            tag_pipe_d[j] = tag_pipe_q[j-1];
        end
    end

    // The final pipe stage is the response itself, so it does not count as in flight.
    always_comb begin
        inflight = |tag_issue_q;
        for (int j = 0; j < SRAM_LAT - 1; j++) begin
            inflight = inflight | (|tag_pipe_q[j]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_OPEN;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            tag_issue_q <= '0;
            for (int j = 0; j < SRAM_LAT; j++) begin
                tag_pipe_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
            tag_issue_q <= tag_issue_d;
            for (int j = 0; j < SRAM_LAT; j++) begin
                tag_pipe_q[j] <= tag_pipe_d[j];
            end
        end
    end

    assign rsp_valid          = tag_pipe_q[SRAM_LAT-1];
    assign rsp_data           = sram_read_data;
    assign sram_write_enable  = we_q;
    assign sram_write_address = waddr_q;
    assign sram_write_data    = wdata_q;
    assign sram_read_address  = raddr_q;
    assign busy               = (state_q == ST_LOCKED) || inflight;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: write-first SRAM model, queue-based reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_sram_rr_arbiter;
    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int LAT = 1;
    localparam int MB  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req_valid, req_lock, req_we, req_ready, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     rsp_data, sram_write_data, sram_read_data;
    logic              sram_write_enable, busy;
    logic [AW-1:0]     sram_write_address, sram_read_address;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sram_rr_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .SRAM_LAT(LAT), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sram_write_enable(sram_write_enable), .sram_write_address(sram_write_address),
        .sram_write_data(sram_write_data), .sram_read_address(sram_read_address),
        .sram_read_data(sram_read_data), .busy(busy)
    );

    // SRAM model: unwritten words read as addr*3, write-first on same-edge collision.
    logic [DW-1:0] mem [1024];
    bit            written [1024];
    logic [DW-1:0] rd_pipe [LAT];

    function automatic logic [DW-1:0] sram_word(logic [AW-1:0] a);
        return written[a[9:0]] ? mem[a[9:0]] : DW'(a) * 3;
    endfunction

    always @(posedge clk) begin
        if (sram_write_enable) begin
            mem[sram_write_address[9:0]]     <= sram_write_data;
            written[sram_write_address[9:0]] <= 1'b1;
        end
        rd_pipe[0] <= (sram_write_enable && sram_write_address == sram_read_address)
                      ? sram_write_data : sram_word(sram_read_address);
        for (int j = 1; j < LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign sram_read_data = rd_pipe[LAT-1];

    // Reference model state
    typedef struct { int due; int req; logic [DW-1:0] data; } rsp_t;
    rsp_t          rq[$];
    logic [DW-1:0] shadow [int];
    int            grant_log[$];
    int            rsp_idx_log[$];
    logic [DW-1:0] rsp_data_log[$];

    function automatic logic [DW-1:0] shadow_rd(int a);
        return shadow.exists(a) ? shadow[a] : DW'(a) * 3;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin : model_and_compare
        int m_ptr, m_owner, m_beats, g, ridx;
        bit m_locked, acc, e_busy;
        logic s_lock, s_we, e_we;
        logic [AW-1:0] s_addr, e_wa, e_ra;
        logic [DW-1:0] s_data, e_wd, e_rdata;
        logic [N-1:0] e_ready, e_rsp;
        m_ptr = 0; m_owner = 0; m_beats = 0; m_locked = 0;
        e_we = 0; e_wa = '0; e_ra = '0; e_wd = '0;
        s_lock = 0; s_we = 0; s_addr = '0; s_data = '0;
        forever begin
            @(negedge clk);
            #4;
            e_ready = '0; acc = 0; g = 0;
            if (reset_n) begin
                if (m_locked) begin
                    if (req_valid[m_owner]) begin acc = 1; g = m_owner; end
                end else begin
                    for (int off = 0; off < N && !acc; off++) begin
                        if (req_valid[(m_ptr + off) % N]) begin acc = 1; g = (m_ptr + off) % N; end
                    end
                end
                if (acc) begin
                    e_ready[g] = 1'b1;
                    s_lock = req_lock[g]; s_we = req_we[g];
                    s_addr = req_addr[g*AW +: AW]; s_data = req_wdata[g*DW +: DW];
                end
            end
            chk("req_ready", req_ready, e_ready);
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                m_ptr = 0; m_owner = 0; m_beats = 0; m_locked = 0;
                e_we = 0; e_wa = '0; e_ra = '0; e_wd = '0;
                rq.delete();
            end else begin
                e_we = 0;
                if (acc) begin
                    grant_log.push_back(g);
                    $display("cyc %0d grant r%0d %s addr=%0d wdata=%0h lock=%0b",
                             cyc, g, s_we ? "WR" : "RD", s_addr, s_data, s_lock);
                    if (s_we) begin
                        e_we = 1; e_wa = s_addr; e_wd = s_data;
                        shadow[int'(s_addr)] = s_data;
                    end else begin
                        e_ra = s_addr;
                        rq.push_back('{cyc + LAT, g, shadow_rd(int'(s_addr))});
                    end
                    if (m_locked) m_beats++;
                    else if (s_lock) begin m_locked = 1; m_owner = g; m_beats = 1; end
                    if (m_locked && (!s_lock || m_beats == MB)) begin
                        m_locked = 0; m_beats = 0;
                    end
                    if (!m_locked) m_ptr = (g + 1) % N;
                end
            end
            e_rsp = '0; e_rdata = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e_rsp[rq[0].req] = 1'b1;
                e_rdata = rq[0].data;
                void'(rq.pop_front());
            end
            e_busy = m_locked;
            foreach (rq[j]) if (rq[j].due > cyc) e_busy = 1;
            #1;
            chk("sram_we", sram_write_enable, e_we);
            chk("sram_waddr", sram_write_address, e_wa);
            chk("sram_wdata", sram_write_data, e_wd);
            chk("sram_raddr", sram_read_address, e_ra);
            chk("rsp_valid", rsp_valid, e_rsp);
            if (e_rsp != '0) chk("rsp_data", rsp_data, e_rdata);
            chk("busy", busy, e_busy);
            if (rsp_valid != '0) begin
                ridx = -1;
                for (int i = 0; i < N; i++) if (rsp_valid[i]) ridx = i;
                rsp_idx_log.push_back(ridx);
                rsp_data_log.push_back(rsp_data);
            end
        end
    end

    task automatic set_req(int i, bit v, bit lk, bit we, int addr, logic [DW-1:0] d);
        req_valid[i] = v; req_lock[i] = lk; req_we[i] = we;
        req_addr[i*AW +: AW] = AW'(addr);
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle();
        req_valid = '0; req_lock = '0; req_we = '0;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin : stimulus
        int bg, br, rc, lock_pct;
        int exp1[5]  = '{0, 1, 2, 3, 0};
        int exp2[7]  = '{2, 2, 2, 2, 2, 0, 1};
        int exp4[4]  = '{2, 2, 2, 3};
        logic [DW-1:0] d1[4] = '{32'd30, 32'd33, 32'd36, 32'd39};
        idle(); req_addr = '0; req_wdata = '0;
        repeat (3) nxt();
        reset_n = 1'b1;
        nxt();

        // Plain round robin, all requesters reading 10+i
        bg = grant_log.size(); br = rsp_data_log.size();
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, 10 + i, '0);
        repeat (5) nxt();
        idle();
        repeat (3) nxt();
        for (int k = 0; k < 5; k++) chk("rr_grant", grant_log[bg + k], exp1[k]);
        for (int k = 0; k < 4; k++) begin
            chk("rr_rsp_idx", rsp_idx_log[br + k], k);
            chk("rr_rsp_data", rsp_data_log[br + k], d1[k]);
        end

        // Requester 2 locks for five writes while 0 and 1 wait
        bg = grant_log.size();
        set_req(2, 1, 1, 1, 100, 32'hA000_0000);
        nxt();
        for (int b = 1; b <= 4; b++) begin
            set_req(2, 1, b < 4, 1, 100 + b, 32'hA000_0000 + b);
            set_req(0, 1, 0, 0, 20, '0);
            set_req(1, 1, 0, 0, 21, '0);
            nxt();
        end
        set_req(2, 0, 0, 0, 0, '0);
        repeat (2) nxt();
        idle();
        repeat (2) nxt();
        for (int k = 0; k < 7; k++) chk("lock5_grant", grant_log[bg + k], exp2[k]);
        br = rsp_data_log.size();
        for (int a = 0; a < 5; a++) begin
            set_req(3, 1, 0, 0, 100 + a, '0);
            nxt();
        end
        idle();
        repeat (3) nxt();
        for (int a = 0; a < 5; a++) begin
            chk("lock5_readback_idx", rsp_idx_log[br + a], 3);
            chk("lock5_readback", rsp_data_log[br + a], 32'hA000_0000 + a);
        end

        // Continuous lock by requester 1 hits the MAX_BURST forced release
        bg = grant_log.size();
        for (int b = 0; b < MB + 4; b++) begin
            set_req(1, 1, 1, 1, 200 + b, DW'(b));
            if (b >= 1) begin
                set_req(0, 1, 0, 0, 30, '0);
                set_req(2, 1, 0, 0, 32, '0);
                set_req(3, 1, 0, 0, 33, '0);
            end
            nxt();
        end
        idle();
        set_req(1, 1, 0, 0, 210, '0);
        nxt();
        idle();
        repeat (3) nxt();
        for (int k = 0; k < MB; k++) chk("burst_owner", grant_log[bg + k], 1);
        chk("burst_after0", grant_log[bg + MB], 2);
        chk("burst_after1", grant_log[bg + MB + 1], 3);
        chk("burst_after2", grant_log[bg + MB + 2], 0);
        chk("burst_after3", grant_log[bg + MB + 3], 1);

        // Locked owner goes idle for three cycles; requester 3 must wait
        bg = grant_log.size();
        set_req(2, 1, 1, 0, 40, '0);
        nxt();
        set_req(3, 1, 0, 0, 41, '0);
        nxt();
        set_req(2, 0, 0, 0, 0, '0);
        repeat (3) begin
            #4;
            chk("hold_ready", req_ready, '0);
            nxt();
        end
        set_req(2, 1, 0, 0, 42, '0);
        nxt();
        set_req(2, 0, 0, 0, 0, '0);
        nxt();
        idle();
        repeat (3) nxt();
        for (int k = 0; k < 4; k++) chk("hold_grant", grant_log[bg + k], exp4[k]);

        // Reset one cycle after a read accept drops the response
        set_req(2, 1, 0, 0, 50, '0);
        nxt();
        idle();
        rc = rsp_data_log.size();
        reset_n = 1'b0;
        repeat (2) nxt();
        reset_n = 1'b1;
        repeat (2) nxt();
        chk("reset_no_rsp", rsp_data_log.size(), rc);
        set_req(3, 1, 0, 0, 61, '0);
        set_req(1, 1, 0, 0, 60, '0);
        nxt();
        idle();
        repeat (3) nxt();
        chk("post_reset_grant", grant_log[grant_log.size() - 1], 1);

        // Write then read the same address on consecutive beats
        set_req(0, 1, 0, 1, 5, 32'hDEAD_BEEF);
        nxt();
        idle();
        set_req(1, 1, 0, 0, 5, '0);
        nxt();
        idle();
        repeat (3) nxt();
        chk("wr_rd_idx", rsp_idx_log[rsp_idx_log.size() - 1], 1);
        chk("wr_rd_data", rsp_data_log[rsp_data_log.size() - 1], 32'hDEAD_BEEF);

        // Random traffic; heavy locking first to exercise forced releases
        for (int c = 0; c < 3000; c++) begin
            lock_pct = (c < 1500) ? 90 : 30;
            for (int i = 0; i < N; i++) begin
                set_req(i, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < lock_pct,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 63), $urandom);
            end
            nxt();
        end
        idle();
        repeat (LAT + 4) nxt();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Shares one single-port-style SRAM interface (separate write and read address buses, 1-cycle read latency) between NUM_REQ requesters.
- Typical requesters: stage-1 MAC sequencer, stage-2 score sequencer, testbench readback.
- Round-robin arbitration, one command per cycle, optional locked bursts with a bounded length.
- Read responses are routed back to the issuing requester by a tag pipeline.
- Sits between the matrix-multiply controllers and the result/scratchpad SRAM ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 16, SRAM address width.
- DATA_W, 32, SRAM data width.
- SRAM_LAT, 1, cycles from address sampled by SRAM to read data valid (1..3).
- MAX_BURST, 16, maximum accepted beats per lock before a forced release (>=2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_lock  in  NUM_REQ  keep grant after this beat (burst continues).
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot or zero grant; combinational. Beat accepted when req_valid[i] && req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot read-data-valid to the issuing requester.
- rsp_data  out  DATA_W  read data; equals sram_read_data.
- sram_write_enable  out  1  registered.
- sram_write_address  out  ADDR_W  registered.
- sram_write_data  out  DATA_W  registered.
- sram_read_address  out  ADDR_W  registered.
- sram_read_data  in  DATA_W  SRAM read data.
- busy  out  1  lock held or any read in flight.

Behaviour:
- Reset values, async on reset_n low:
  - req_ready = 0, rsp_valid = 0, sram_write_enable = 0.
  - sram addresses = 0, sram_write_data = 0, busy = 0.
  - Pointer = 0, owner cleared, burst count = 0, tag pipeline cleared.
- States:
  - OPEN: grant goes to the first requester with req_valid set, searching from pointer upward, modulo NUM_REQ.
  - LOCKED(owner): req_ready = owner bit only, and only while req_valid[owner] is high.
- Transitions:
  - OPEN -> LOCKED: accepted beat with req_lock=1.
  - LOCKED -> OPEN: accepted beat with req_lock=0, or the accepted beat that makes burst count = MAX_BURST (forced release regardless of req_lock).
  - In LOCKED, req_valid[owner] low holds the lock; no other requester is granted (idle cycle).
- Pointer update:
  - After every accepted beat that ends in OPEN, pointer <= granted index + 1 (mod NUM_REQ).
  - Unchanged during locked beats.
  - Burst count resets to 0 on entry to OPEN and counts accepted beats while locked.
- SRAM command on a beat accepted at edge k:
  - Outputs update at edge k and are valid for the cycle after edge k.
  - Write: sram_write_enable=1 with that requester's address and data.
  - Read: sram_read_address=addr, sram_write_enable=0.
  - No accept: sram_write_enable=0; address and data registers hold their values.
- Read response:
  - The requester's one-hot tag enters a SRAM_LAT-deep shift register at edge k+1.
  - rsp_valid[i]=1 for exactly one cycle, the cycle following edge k+1+SRAM_LAT-1 (SRAM_LAT=1: cycle after edge k+1).
  - Back-to-back reads give back-to-back responses in issue order.
  - Writes produce no response.
- Same-address write then read on consecutive beats is ordered by issue. The read returns the new data if the SRAM is write-first; the arbiter adds no forwarding.
- No requester valid: grant 0, no SRAM activity, pointer unchanged.
- Reset mid-burst or with reads in flight: all tags dropped, no rsp_valid after reset releases, lock lost. Requesters must reissue.
- req_ready is never asserted to a requester with req_valid low.

Test Plan:
- All 4 valid, no lock, reads to addr 10+i, SRAM returns addr*3 -> grants 0,1,2,3,0 on consecutive cycles; rsp_valid one-hot to 0,1,2,3 with data 30,33,36,39, each 2 cycles after its accept.
- Req 2 locks for 5 writes (lock=1 on beats 1-4, 0 on beat 5) while req 0,1 valid -> only 2 granted for 5 cycles; next grants 3-skip, then 0; memory holds the 5 writes.
- MAX_BURST=16, req 1 holds lock=1 continuously -> forced release after 16th beat; req 2 (valid) granted next cycle; req 1 re-granted only after 2,3,0 are served.
- Locked owner drops req_valid for 3 cycles while req 3 valid -> req_ready stays 0, no SRAM command, owner resumes; req 3 waits.
- Reset asserted one cycle after a read accept -> rsp_valid stays 0 through and after reset; pointer 0; first post-reset grant goes to lowest valid index.
- Write addr 5 = 0xDEADBEEF by req 0, then read addr 5 by req 1 the next cycle -> rsp_valid[1] with 0xDEADBEEF (write-first SRAM model).
